seg7_scan_driver: RTL and testbench

- Parametrised, time-multiplexed driver for an NUM_DIGITS-digit common-anode seven-segment display.
- Latches a hex value and decimal-point mask, then applies them tear-free at frame boundaries.
- Scans digits with a programmable dwell time and an anti-ghosting guard interval, with optional leading-zero blanking.
- Sits between the value-producing logic (counters, VGA debug taps) and the board's segment and anode pins.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_hex_rom.sv | 33 +++
 rtl/seg7_scan_driver.sv | 205 ++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: blank code, hex segment
// codes (active-low, bit0 = a .. bit6 = g) and the anode polarity helper.
package seg7_pkg;

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  localparam logic [6:0] SEG7_HEX_0 = 7'h40;
  localparam logic [6:0] SEG7_HEX_1 = 7'h79;
  localparam logic [6:0] SEG7_HEX_2 = 7'h24;
  localparam logic [6:0] SEG7_HEX_3 = 7'h30;
  localparam logic [6:0] SEG7_HEX_4 = 7'h19;
  localparam logic [6:0] SEG7_HEX_5 = 7'h12;
  localparam logic [6:0] SEG7_HEX_6 = 7'h02;
  localparam logic [6:0] SEG7_HEX_7 = 7'h78;
  localparam logic [6:0] SEG7_HEX_8 = 7'h00;
  localparam logic [6:0] SEG7_HEX_9 = 7'h10;
  localparam logic [6:0] SEG7_HEX_A = 7'h08;
  localparam logic [6:0] SEG7_HEX_B = 7'h03;
  localparam logic [6:0] SEG7_HEX_C = 7'h46;
  localparam logic [6:0] SEG7_HEX_D = 7'h21;
  localparam logic [6:0] SEG7_HEX_E = 7'h06;
  localparam logic [6:0] SEG7_HEX_F = 7'h0E;

  // Level that turns an anode on for the given polarity.
  function automatic logic an_on_level(input logic active_low);
    return active_low ? 1'b0 : 1'b1;
  endfunction

endpackage

// File: rtl/seg7_hex_rom.sv
// Combinational hex nibble to active-low seven-segment code.
module seg7_hex_rom
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Hex decode table.
  always_comb begin
    seg = SEG7_BLANK;
    case (nibble)
      4'h0:    seg = SEG7_HEX_0;
      4'h1:    seg = SEG7_HEX_1;
      4'h2:    seg = SEG7_HEX_2;
      4'h3:    seg = SEG7_HEX_3;
      4'h4:    seg = SEG7_HEX_4;
      4'h5:    seg = SEG7_HEX_5;
      4'h6:    seg = SEG7_HEX_6;
      4'h7:    seg = SEG7_HEX_7;
      4'h8:    seg = SEG7_HEX_8;
      4'h9:    seg = SEG7_HEX_9;
      4'hA:    seg = SEG7_HEX_A;
      4'hB:    seg = SEG7_HEX_B;
      4'hC:    seg = SEG7_HEX_C;
      4'hD:    seg = SEG7_HEX_D;
      4'hE:    seg = SEG7_HEX_E;
      4'hF:    seg = SEG7_HEX_F;
      default: seg = SEG7_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with tear-free frame updates, guard
// interval and leading-zero blanking. Define SEG7_SCAN_BLINK_EN for per-digit blink.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SCAN_DIV      = 50000,
  parameter int GUARD         = 2,
  parameter int AN_ACTIVE_LOW = 1
`ifdef SEG7_SCAN_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_load,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_blank_lz,
`ifdef SEG7_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   i_blink,
`endif
  output logic [6:0]              o_seg7,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic                    o_frame
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [CW:0]   GUARD_W  = (CW + 1)'(GUARD);
  localparam logic          AN_ON    = an_on_level(AN_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = {NUM_DIGITS{~AN_ON}};

  logic [CW-1:0]           cnt_r;
  logic [DW-1:0]           dig_r;
  logic [4*NUM_DIGITS-1:0] shadow_val_r, active_val_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r, active_dp_r;
  logic                    pending_r;
  logic [6:0]              seg_r;
  logic                    dp_r;
  logic [NUM_DIGITS-1:0]   an_r;
  logic                    frame_r;

  logic                    boundary_s, in_guard_s, blink_hide_s;
  logic [NUM_DIGITS-1:0]   sel_s, an_sel_s, lz_mask_s;
  logic [3:0]              nibble_s;
  logic                    dp_bit_s, lz_sel_s, zero_above_s;
  logic [6:0]              rom_seg_s, seg_next_s;
  logic                    dp_next_s;
  logic [NUM_DIGITS-1:0]   an_next_s;

  assign boundary_s = (cnt_r == CNT_LAST) && (dig_r == DIG_LAST);
  assign in_guard_s = ({1'b0, cnt_r} < GUARD_W);

  // Dwell prescaler and digit index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_r <= '0;
      dig_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
      dig_r <= (dig_r == DIG_LAST) ? '0 : dig_r + 1'b1;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // Shadow capture and frame-boundary commit; a load on the boundary bypasses the shadow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shadow_val_r <= '0;
      shadow_dp_r  <= '0;
      active_val_r <= '0;
      active_dp_r  <= '0;
      pending_r    <= 1'b0;
    end else begin
      if (i_load) begin
        shadow_val_r <= i_value;
        shadow_dp_r  <= i_dp;
      end
      if (boundary_s) begin
        pending_r <= 1'b0;
        if (i_load) begin
          active_val_r <= i_value;
          active_dp_r  <= i_dp;
        end else if (pending_r) begin
          active_val_r <= shadow_val_r;
          active_dp_r  <= shadow_dp_r;
        end
      end else if (i_load) begin
        pending_r <= 1'b1;
      end
    end
  end

  // Digit select and anode pattern for the current slot.
  always_comb begin
    sel_s    = '0;
    an_sel_s = AN_ALL_OFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      sel_s[k]    = (dig_r == DW'(k));
      an_sel_s[k] = sel_s[k] ? AN_ON : ~AN_ON;
    end
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    lz_mask_s    = '0;
    zero_above_s = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above_s = zero_above_s & (active_val_r[4*k +: 4] == 4'h0);
      lz_mask_s[k] = zero_above_s & (k != 0);
    end
  end

  // AND-OR mux of the selected digit's nibble, dp and blank flag.
  always_comb begin
    nibble_s = 4'h0;
    dp_bit_s = 1'b0;
    lz_sel_s = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      nibble_s = nibble_s | (active_val_r[4*k +: 4] & {4{sel_s[k]}});
      dp_bit_s = dp_bit_s | (active_dp_r[k] & sel_s[k]);
      lz_sel_s = lz_sel_s | (lz_mask_s[k] & sel_s[k]);
    end
  end

  seg7_hex_rom u_hex_rom (
    .nibble (nibble_s),
    .seg    (rom_seg_s)
  );

`ifdef SEG7_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] frame_cnt_r;
  logic          blink_phase_r;

  // Blink phase toggles once every BLINK_FRAMES frames.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else if (boundary_s) begin
      if (frame_cnt_r == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        frame_cnt_r <= frame_cnt_r + 1'b1;
      end
    end
  end

  assign blink_hide_s = blink_phase_r & (|(i_blink & sel_s));
`else
  assign blink_hide_s = 1'b0;
`endif

  // Next output values: guard slot first, then blink, blanking, normal decode.
  always_comb begin
    seg_next_s = SEG7_BLANK;
    dp_next_s  = 1'b1;
    an_next_s  = AN_ALL_OFF;
    if (in_guard_s) begin
      seg_next_s = SEG7_BLANK;
      dp_next_s  = 1'b1;
      an_next_s  = AN_ALL_OFF;
    end else begin
      an_next_s = an_sel_s;
      if (blink_hide_s) begin
        seg_next_s = SEG7_BLANK;
        dp_next_s  = 1'b1;
      end else if (i_blank_lz && lz_sel_s) begin
        seg_next_s = SEG7_BLANK;
        dp_next_s  = ~dp_bit_s;
      end else begin
        seg_next_s = rom_seg_s;
        dp_next_s  = ~dp_bit_s;
      end
    end
  end

  // Registered pin drivers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      seg_r   <= SEG7_BLANK;
      dp_r    <= 1'b1;
      an_r    <= AN_ALL_OFF;
      frame_r <= 1'b0;
    end else begin
      seg_r   <= seg_next_s;
      dp_r    <= dp_next_s;
      an_r    <= an_next_s;
      frame_r <= boundary_s;
    end
  end

  assign o_seg7  = seg_r;
  assign o_dp    = dp_r;
  assign o_an    = an_r;
  assign o_frame = frame_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a frame-level reference model.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int GD = 1;
  localparam int FL = ND * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg7;
  logic        odp;
  logic [3:0]  an;
  logic        frame;

  seg7_scan_driver #(
    .NUM_DIGITS    (ND),
    .SCAN_DIV      (SD),
    .GUARD         (GD),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (load),
    .i_value    (value),
    .i_dp       (dp),
    .i_blank_lz (blank_lz),
    .o_seg7     (seg7),
    .o_dp       (odp),
    .o_an       (an),
    .o_frame    (frame)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_pass   = 0;

  // Model: cycles since reset, the displayed value and the most recent load.
  int          m_t = 0;
  logic [15:0] m_active_val = 16'h0, m_last_val = 16'h0;
  logic [3:0]  m_active_dp = 4'h0, m_last_dp = 4'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  task automatic tick();
    int          cnt, dig;
    logic [15:0] hi;
    logic [3:0]  nib;
    logic [6:0]  e_seg;
    logic [3:0]  e_an;
    logic        e_dp, e_frame;
    @(posedge clk);
    e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1; e_frame = 1'b0;
    if (rst) begin
      m_t = 0;
      m_active_val = 16'h0; m_last_val = 16'h0;
      m_active_dp = 4'h0;   m_last_dp = 4'h0;
    end else begin
      cnt = m_t % SD;
      dig = (m_t / SD) % ND;
      e_frame = ((m_t % FL) == FL - 1);
      if (cnt >= GD) begin
        e_an = ~(4'b0001 << dig);
        hi   = m_active_val >> (4 * dig);
        nib  = hi[3:0];
        e_seg = (blank_lz && dig > 0 && hi == 16'h0) ? 7'h7F : seg_tab[nib];
        e_dp  = ~m_active_dp[dig];
      end
      if (load) begin m_last_val = value; m_last_dp = dp; end
      if (e_frame) begin m_active_val = m_last_val; m_active_dp = m_last_dp; end
      m_t++;
    end
    #1;
    check("seg7", 32'(seg7), 32'(e_seg));
    check("an", 32'(an), 32'(e_an));
    check("dp", 32'(odp), 32'(e_dp));
    check("frame", 32'(frame), 32'(e_frame));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value = v; dp = d;
    tick();
    load = 1'b0;
  endtask

  // Advance until the next edge is the frame-boundary edge.
  task automatic to_boundary();
    for (int i = 0; i < FL && (m_t % FL) != FL - 1; i++) tick();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic seen;
    logic [15:0] mask;
    tick(); tick();
    check("rst_an", 32'(an), 32'h0000000F);
    check("rst_seg", 32'(seg7), 32'h0000007F);
    rst = 1'b0;
    tick();
    check("rel_an", 32'(an), 32'h0000000F);
    check("rel_frame", 32'(frame), 32'h0);
    tick();
    check("first_an", 32'(an), 32'h0000000E);
    check("first_seg", 32'(seg7), 32'h00000040);

    // Mid-frame load becomes visible only after the next frame pulse.
    run(5);
    do_load(16'h1234, 4'b0100);
    seen = 1'b0;
    for (int i = 0; i < 2 * FL && !seen; i++) begin tick(); seen = frame; end
    check("frame_seen", 32'(seen), 32'h1);
    run(FL + 3);

    // Leading-zero blanking on and off.
    blank_lz = 1'b1;
    do_load(16'h0070, 4'b0000);
    run(2 * FL);
    blank_lz = 1'b0;
    run(FL);

    // Earlier load overridden by a load on the boundary cycle.
    run(3);
    do_load(16'h5555, 4'b1111);
    to_boundary();
    do_load(16'hABCD, 4'b0001);
    check("bypass_frame", 32'(frame), 32'h1);
    run(FL + 2);

    // Reset while digit 2 is being displayed.
    for (int i = 0; i < FL && !(((m_t / SD) % ND) == 2 && (m_t % SD) >= GD); i++) tick();
    rst = 1'b1;
    tick();
    check("midrst_an", 32'(an), 32'h0000000F);
    check("midrst_seg", 32'(seg7), 32'h0000007F);
    rst = 1'b0;
    run(FL + 2);

    // Randomized traffic.
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 4))
          0: mask = 16'hFFFF;
          1: mask = 16'h0FFF;
          2: mask = 16'h00FF;
          3: mask = 16'h000F;
          default: mask = 16'h0000;
        endcase
        load  = 1'b1;
        value = 16'($urandom) & mask;
        dp    = 4'($urandom);
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 19) == 0) blank_lz = ~blank_lz;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    load = 1'b0;
    rst  = 1'b0;
    run(2 * FL);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
